max_pool_3_bram_reader: RTL
===========================

Name: max_pool_3_bram_reader

Overview:
- Read-side master for the max_pool_3 dual-port result BRAM. Drives one BRAM port (Port B) as a read-only initiator and drains NUM_WORDS consecutive 32-bit words.
- Streams the words in order over a valid/ready interface to the next layer, the flatten/dense stage.
- Absorbs BRAM read latency and downstream backpressure with a small credit-controlled FIFO, so throughput is one word per cycle when the consumer is always ready.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word in the BRAM.
- NUM_WORDS, 1024, number of 32-bit words per transfer. Must be ≥1.
- READ_LATENCY, 1, cycles from en/addr to valid bram_dout. Legal values are 1 and 2.
- FIFO_DEPTH, 4, output buffer entries. Must be ≥ READ_LATENCY+2.

Ports:
- clk  in  1  sole clock; the BRAM port clock is driven from it.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer.
- busy  out  1  high while a transfer is active.
- done  out  1  one-cycle pulse after the final output handshake.
- bram_addr  out  32  byte address = BASE_ADDR + 4*index.
- bram_en  out  1  read enable, one read per high cycle.
- bram_we  out  4  always 4'b0000.
- bram_din  out  32  always 0.
- bram_dout  in  32  BRAM read data.
- m_data  out  32  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final word (index NUM_WORDS-1).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; in-flight tracker cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE→READ: start=1. Read index is cleared to 0 and busy rises in the next cycle.
  - READ→DRAIN: the read for index NUM_WORDS-1 is issued.
  - DRAIN→DONE: the handshake on the m_last word completes.
  - DONE: done=1 and busy=0 for exactly one cycle, then the FSM returns to IDLE.
- start is ignored outside IDLE, including in the DONE cycle.
- Read issue:
  - In READ, bram_en=1 when in_flight + fifo_count < FIFO_DEPTH. The count does not credit a same-cycle pop.
  - Each issue increments the index; bram_addr advances by 4 per issue.
  - bram_addr holds its last value when en is low.
  - Address arithmetic is modulo 2^32.
- Capture:
  - A read issued in cycle c has valid data on bram_dout in cycle c+READ_LATENCY.
  - That data is written to the FIFO at the end of that cycle and the entry is visible at the FIFO head the following cycle.
  - A READ_LATENCY-deep valid shift register tracks in-flight reads.
- Output:
  - m_valid = FIFO not empty; m_data and m_last come from the FIFO head.
  - A handshake is m_valid & m_ready. The FIFO pushes and pops in the same cycle without loss.
  - While m_valid=1 and m_ready=0, m_data and m_last must hold stable.
- Latency:
  - With start sampled in cycle 0: bram_en first high in cycle 1, m_valid first high in cycle 2+READ_LATENCY.
  - With m_ready held high, words appear on consecutive cycles and done pulses the cycle after the last handshake.
- Overflow is impossible by construction. A FIFO push while full is a design error; the bench asserts it never happens.
- Reset mid-operation:
  - Immediate return to IDLE with an empty FIFO.
  - Data still returning from BRAM after reset is discarded (tracker cleared).
  - No done pulse is generated.
- m_last is attached to the word at the moment of capture, not inferred from the output count.

Test Plan:
- Basic: NUM_WORDS=8, READ_LATENCY=1, BRAM preloaded with word[i]=32'hA000_0000+i, m_ready=1, start in cycle 0.
  - bram_en high in cycles 1–8 with addr 0x00..0x1C.
  - m_valid in cycles 3–10 with data A000_0000..A000_0007; m_last only in cycle 10.
  - done in cycle 11; busy high in cycles 1–10.
- Backpressure: same setup with m_ready=0 for cycles 0–9, then 1.
  - bram_en drops after 4 issues (FIFO_DEPTH=4).
  - m_data stays A000_0000 while stalled; all 8 words delivered in order with no duplicates.
  - done exactly once.
- Random ready: NUM_WORDS=64, m_ready random at 50%.
  - Output sequence equals memory contents 0..63.
  - No FIFO overflow; bram_we=0 and bram_din=0 throughout.
- Latency 2: READ_LATENCY=2, NUM_WORDS=8, m_ready=1.
  - First m_valid in cycle 4; words arrive back-to-back; done in cycle 12.
- Start while busy: pulse start again in cycle 5 of a NUM_WORDS=8 run.
  - Ignored; exactly 8 words and one done.
  - A subsequent start after done re-reads from BASE_ADDR.
- Reset mid-stream: assert rst in cycle 6 of a NUM_WORDS=16 run.
  - Next cycle: all outputs 0, no stray m_valid from in-flight reads, no done.
  - A new start then delivers the full 16 words from index 0.

Source files
------------

// File: rtl/max_pool_3_bram_reader.sv
// Read-side master for the max_pool_3 result BRAM. Drains NUM_WORDS words over BRAM port B and
// streams them in order on a valid/ready interface, using a credit-controlled output FIFO.
module max_pool_3_bram_reader #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          NUM_WORDS    = 1024,
    parameter int          READ_LATENCY = 1,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] bram_addr,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_din,
    input  logic [31:0] bram_dout,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]        r_idx;
    logic [31:0]             r_addr_hold;
    logic [READ_LATENCY-1:0] r_vld_p;
    logic [READ_LATENCY-1:0] r_lst_p;

    logic [DATA_W:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic                    w_issue;
    logic                    w_last_issue;
    logic                    w_push;
    logic                    w_pop;
    logic [CNT_W:0]          w_inflight;
    logic [CNT_W:0]          w_credit_used;
    logic [31:0]             w_cur_addr;
    logic [DATA_W:0]         w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit: reads in flight plus stored entries; a same-cycle pop is deliberately not credited.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + (CNT_W+1)'(r_vld_p[i]);
        end
        w_credit_used = w_inflight + (CNT_W+1)'(r_count);
    end

    assign w_issue      = (r_state == S_READ) && (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_idx == LAST_IDX);
    assign w_cur_addr   = BASE_ADDR + (32'(r_idx) << 2);
    assign w_push       = r_vld_p[READ_LATENCY-1];
    assign w_head       = r_mem[r_rd_ptr];
    assign m_valid      = (r_count != '0);
    assign w_pop        = m_valid && m_ready;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_READ;
            end
            S_READ: begin
                busy = 1'b1;
                if (w_last_issue) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_pop && w_head[DATA_W]) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM, read index, in-flight tracker, FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_addr_hold <= '0;
            r_vld_p     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_idx <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_issue) r_addr_hold <= w_cur_addr;
            r_vld_p <= READ_LATENCY'({r_vld_p, w_issue});
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture stage: last flag rides alongside the read so it is bound to the word, not a count.
    always_ff @(posedge clk) begin
        r_lst_p <= READ_LATENCY'({r_lst_p, w_last_issue});
        if (w_push) r_mem[r_wr_ptr] <= {r_lst_p[READ_LATENCY-1], bram_dout};
    end

    assign bram_en   = w_issue;
    assign bram_addr = w_issue ? w_cur_addr : r_addr_hold;
    assign bram_we   = 4'b0000;
    assign bram_din  = '0;
    assign m_data    = m_valid ? w_head[DATA_W-1:0] : '0;
    assign m_last    = m_valid & w_head[DATA_W];

endmodule
